// File: rtl/rotmat_pkg.sv
// Types shared by the quat_to_rotmat front-end: quaternion and rotation-matrix
// layouts, the arbiter state encoding and the Q1.30 unit constant.
package rotmat_pkg;

  localparam int QUAT_W = 32;
  localparam logic [31:0] Q_ONE = 32'h4000_0000;

  typedef struct packed {
    logic signed [QUAT_W-1:0] qw;
    logic signed [QUAT_W-1:0] qx;
    logic signed [QUAT_W-1:0] qy;
    logic signed [QUAT_W-1:0] qz;
  } quat_t;

  // r00 sits in the MSBs, matching the datapath output bus
  typedef struct packed {
    logic signed [31:0] r00;
    logic signed [31:0] r01;
    logic signed [31:0] r02;
    logic signed [31:0] r10;
    logic signed [31:0] r11;
    logic signed [31:0] r12;
    logic signed [31:0] r20;
    logic signed [31:0] r21;
    logic signed [31:0] r22;
  } rotmat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic rotmat_t rotmat_identity();
    rotmat_t r;
    r     = '0;
    r.r00 = Q_ONE;
    r.r11 = Q_ONE;
    r.r22 = Q_ONE;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head shows the oldest entry whenever
// the FIFO is non-empty. A push on a full FIFO is accepted only alongside a pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rotmat_req_arbiter.sv
// Round-robin front-end sharing one quat_to_rotmat datapath between NREQ
// requesters, with tag tracking, credit-protected result buffering and a tagged response.
module rotmat_req_arbiter
  import rotmat_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int W        = 32,
  parameter int RQ_DEPTH = 4,
  parameter int IDW      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_enable,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*4*W-1:0]    req_quat,
  output logic                   q2r_in_valid,
  output logic [4*W-1:0]         q2r_quat,
  input  logic                   q2r_out_valid,
  input  logic [9*32-1:0]        q2r_rot,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [9*32-1:0]        resp_rot,
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int CW = $clog2(RQ_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(RQ_DEPTH);

  typedef struct packed {
    logic [IDW-1:0] id;
    rotmat_t        rot;
  } result_t;

  localparam int RES_W = $bits(result_t);

  arb_state_e     state_q;
  arb_state_e     state_d;
  logic [CW-1:0]  credits_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] rr_ptr_next;
  logic [IDW-1:0] issue_tag_q;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic [4*W-1:0] grant_quat;
  logic           req_hs;
  logic           resp_hs;
  int             cand;

  logic           tag_empty;
  logic [IDW-1:0] tag_head;
  logic           tag_pop;
  logic           res_push;
  logic           res_pop;
  logic           res_empty;
  result_t        res_in;
  result_t        res_head;
  rotmat_t        rot_in;

  assign busy    = (credits_q != FULL_CREDITS) | q2r_in_valid;
  assign req_hs  = |(req_valid & req_ready);
  assign resp_hs = resp_valid & resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // DRAIN waits for every outstanding credit to come back before idling
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_enable) state_d = RUN;
      RUN:     if (!cfg_enable) state_d = DRAIN;
      DRAIN: begin
        if (cfg_enable)  state_d = RUN;
        else if (!busy)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan from the RR pointer and pick the first valid requester, wrapping
  always_comb begin
    req_ready   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    grant_quat  = '0;
    cand        = 0;
    if (state_q == RUN && credits_q != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (int'(rr_ptr_q) + k) % NREQ;
        for (int j = 0; j < NREQ; j++) begin
          if (!grant_found && j == cand && req_valid[j]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(j);
          end
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (grant_found && grant_idx == IDW'(j)) begin
          req_ready[j] = 1'b1;
          grant_quat   = req_quat[j*4*W +: 4*W];
        end
      end
    end
  end

  assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Issue stage: one-cycle pulse to the datapath, tag follows into the tag FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q2r_in_valid <= 1'b0;
      q2r_quat     <= '0;
      issue_tag_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      q2r_in_valid <= req_hs;
      if (req_hs) begin
        q2r_quat    <= grant_quat;
        issue_tag_q <= grant_idx;
        rr_ptr_q    <= rr_ptr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= FULL_CREDITS;
    end else begin
      case ({req_hs, resp_hs})
        2'b10:   credits_q <= credits_q - 1'b1;
        2'b01:   credits_q <= credits_q + 1'b1;
        default: credits_q <= credits_q;
      endcase
    end
  end

  assign tag_pop    = q2r_out_valid & ~tag_empty;
  assign res_push   = tag_pop;
  assign rot_in     = rotmat_t'(q2r_rot);
  assign res_in.id  = tag_head;
  assign res_in.rot = rot_in;

  sync_fifo_fwft #(
    .WIDTH (IDW),
    .DEPTH (RQ_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q2r_in_valid),
    .push_data (issue_tag_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty)
  );

  sync_fifo_fwft #(
    .WIDTH (RES_W),
    .DEPTH (RQ_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data (res_in),
    .pop       (res_pop),
    .head      (res_head),
    .empty     (res_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_orphan <= 1'b0;
    else if (q2r_out_valid && tag_empty) err_orphan <= 1'b1;
  end

  // Output register refills whenever it is empty or being consumed
  assign res_pop = ~res_empty & (~resp_valid | resp_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_rot   <= '0;
    end else if (res_pop) begin
      resp_valid <= 1'b1;
      resp_id    <= res_head.id;
      resp_rot   <= res_head.rot;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rotmat_req_arbiter.md
Name: rotmat_req_arbiter

Overview:
- Shares one quat_to_rotmat datapath instance between NREQ pose requesters, for example the IMU propagation path and the scan-registration path.
- Arbitrates round-robin, issues quaternions to the datapath and tags each one in flight.
- Captures the rotation matrices into a credit-protected result FIFO and returns them on a single tagged response stream.
- Sits in point_processing, directly wrapping the quat_to_rotmat instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 32, quaternion component width (Q1.30).
- RQ_DEPTH, 4, result FIFO depth; also the credit pool and the tag FIFO depth (power of 2, at least 2).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- cfg_enable  in  1  1 = grant requests; 0 = stop granting and drain.
- req_valid  in  NREQ  per-requester quaternion valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_quat  in  NREQ*4*W  per requester {qw,qx,qy,qz}; requester i occupies slice i.
- q2r_in_valid  out  1  to datapath in_valid.
- q2r_quat  out  4*W  to datapath {qw,qx,qy,qz}.
- q2r_out_valid  in  1  from datapath out_valid.
- q2r_rot  in  9*32  from datapath {r00..r22}, r00 in the MSBs.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accept.
- resp_id  out  IDW  originating requester.
- resp_rot  out  9*32  rotation matrix.
- busy  out  1  requests in flight or results buffered.
- err_orphan  out  1  sticky; datapath produced a result with no tag outstanding.

Behaviour:
- Reset values: req_ready=0, q2r_in_valid=0, q2r_quat=0, resp_valid=0, resp_id=0, resp_rot=0, busy=0, err_orphan=0. Credits reset to RQ_DEPTH, RR pointer to 0, both FIFOs empty, state IDLE.
- FSM states:
  - IDLE: go to RUN when cfg_enable=1.
  - RUN: go to DRAIN when cfg_enable=0.
  - DRAIN: no grants. Go to IDLE when busy=0; go back to RUN if cfg_enable=1 first.
- Grant, combinational from registered state:
  - In RUN with credits>0, req_ready is one-hot on the first valid requester at or after the RR pointer, wrapping modulo NREQ. Otherwise req_ready=0.
  - Handshake is req_valid&req_ready.
  - On a handshake from requester g, the RR pointer moves to (g+1) mod NREQ.
  - A requester holding req_valid with stable data is served within NREQ grants.
- Issue:
  - The handshake in cycle t registers q2r_quat and q2r_in_valid=1 for exactly cycle t+1.
  - At most one issue per cycle.
  - The tag g is pushed into the tag FIFO at t+1.
- Credits:
  - Decrement on each handshake; increment on each resp handshake (resp_valid&resp_ready). Simultaneous decrement and increment leave credits unchanged.
  - Credits never exceed RQ_DEPTH and never go below 0, so tag-FIFO plus result-FIFO occupancy is always <= RQ_DEPTH and neither FIFO can overflow.
- Return:
  - On q2r_out_valid: pop the tag FIFO and push {tag, q2r_rot} into the result FIFO in the same cycle.
  - If the tag FIFO is empty, set err_orphan (sticky until reset) and drop the result.
  - Datapath latency is not a parameter here. Ordering is FIFO, and the datapath is in-order.
- Response:
  - resp_* is driven from the result FIFO head, registered.
  - resp_id and resp_rot must stay stable while resp_valid=1 and resp_ready=0.
  - A push into an empty FIFO appears as resp_valid no earlier than the next cycle.
  - Full throughput: one response per cycle while the FIFO is non-empty and resp_ready=1.
- busy = (credits != RQ_DEPTH) | q2r_in_valid.
- Boundary conditions:
  - credits=0 blocks grants; the next cycle after a resp pop re-enables them.
  - A tag push and tag pop in the same cycle on an empty tag FIFO is legal (pop sees the prior content, so this case is an orphan and err_orphan is set).
  - A result push and response pop in the same cycle on a full result FIFO is legal.
  - Pointer wrap is handled modulo RQ_DEPTH.
  - cfg_enable dropping mid-cycle only affects grants from the next registered state. A handshake already in progress completes.
- Asynchronous reset mid-operation discards in-flight tags and results. The integrator resets the datapath together with this block.

Decomposition:
- Shared package rotmat_pkg:
  - quat_t: struct of 4 signed W fields.
  - rotmat_t: 9 signed 32-bit fields.
  - arb_state_e: IDLE/RUN/DRAIN.
  - Q_ONE constant = 32'h4000_0000.
- One sub-module, sync_fifo_fwft (parameterised width and depth), instantiated twice: as the tag FIFO and the result FIFO.

Test Plan:
- Single request:
  - Stimulus: requester 0 sends (0x40000000,0,0,0); the datapath model has 4-cycle latency.
  - Response: q2r_in_valid one cycle after the handshake; later resp_id=0 with r00=r11=r22=0x40000000 and all other entries 0.
  - busy returns to 0.
- Round-robin fairness:
  - Stimulus: both requesters hold valid continuously for 8 grants.
  - Response: grant order 0,1,0,1,…; resp_id sequence matches the issue order.
- Credit backpressure:
  - Stimulus: RQ_DEPTH=4, resp_ready=0, requesters stream.
  - Response: exactly 4 handshakes, then req_ready=0.
  - Stimulus: one resp pop.
  - Response: exactly one more grant.
  - No result is lost or duplicated.
- Drain:
  - Stimulus: drop cfg_enable with 3 requests in flight.
  - Response: no new grants; all 3 responses delivered; FSM goes DRAIN→IDLE with busy=0.
  - Stimulus: re-enable.
  - Response: grants resume from the saved RR pointer.
- Orphan:
  - Stimulus: pulse q2r_out_valid with no tags outstanding.
  - Response: err_orphan=1 and stays set; resp_valid stays 0; normal traffic afterwards is unaffected.
- Async reset:
  - Stimulus: assert rst with results buffered and resp_ready=0.
  - Response: all outputs reach their reset values without a clock edge; credits=RQ_DEPTH after release.
